// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction and resolves RAW hazards ahead of the ALU.
// Define ALU_FWD_EN for EX/MEM and MEM/WB forwarding; without it every RAW hazard stalls.
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic            in_a_sel,
    input  logic            in_b_sel,
    input  logic [3:0]      in_alu_control,
    input  logic            in_sgn,
    input  logic            in_is_load,
    input  logic            in_reg_write,
    input  logic            exm_valid,
    input  logic            exm_reg_write,
    input  logic            exm_is_load,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_valid,
    input  logic            mwb_reg_write,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alu_control,
    output logic            out_sgn,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_is_load
);
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic            r_use_rs1;
    logic            r_use_rs2;
    logic            r_a_sel;
    logic            r_b_sel;
    logic [3:0]      r_alu_control;
    logic            r_sgn;
    logic            r_is_load;
    logic            r_reg_write;

    logic            w_consume;
    logic            w_accept;
    logic            w_hazard;
    logic            w_mwb_wr;
    logic            w_mwb_rs1;
    logic            w_mwb_rs2;
    logic [XLEN-1:0] w_cap_rs1;
    logic [XLEN-1:0] w_cap_rs2;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    // A MEM/WB write to x0 is never visible, so rd != 0 gates every match.
    assign w_mwb_wr  = mwb_valid && mwb_reg_write && (mwb_rd != 5'd0);
    assign w_mwb_rs1 = w_mwb_wr && (mwb_rd == r_rs1);
    assign w_mwb_rs2 = w_mwb_wr && (mwb_rd == r_rs2);
    assign w_cap_rs1 = (w_mwb_wr && (mwb_rd == in_rs1)) ? mwb_result : in_rs1_data;
    assign w_cap_rs2 = (w_mwb_wr && (mwb_rd == in_rs2)) ? mwb_result : in_rs2_data;

`ifdef ALU_FWD_EN
    logic w_exm_fwd;
    logic w_exm_load;

    // A load in EX/MEM has no data yet: it cannot forward and stalls its consumers.
    assign w_exm_fwd  = exm_valid && exm_reg_write && !exm_is_load && (exm_rd != 5'd0);
    assign w_exm_load = exm_valid && exm_reg_write && exm_is_load && (exm_rd != 5'd0);
    assign w_hazard   = w_exm_load && ((r_use_rs1 && (exm_rd == r_rs1)) ||
                                       (r_use_rs2 && (exm_rd == r_rs2)));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_rs1_fwd = r_rs1_data;
        w_rs2_fwd = r_rs2_data;
        if (w_exm_fwd && (exm_rd == r_rs1)) w_rs1_fwd = exm_result;
        else if (w_mwb_rs1)                 w_rs1_fwd = mwb_result;
        if (w_exm_fwd && (exm_rd == r_rs2)) w_rs2_fwd = exm_result;
        else if (w_mwb_rs2)                 w_rs2_fwd = mwb_result;
    end
`else
    logic w_exm_wr;
    logic w_unused_exm;

    assign w_exm_wr     = exm_valid && exm_reg_write && (exm_rd != 5'd0);
    assign w_unused_exm = ^{exm_is_load, exm_result};
    assign w_hazard     = (r_use_rs1 && ((w_exm_wr && (exm_rd == r_rs1)) || w_mwb_rs1)) ||
                          (r_use_rs2 && ((w_exm_wr && (exm_rd == r_rs2)) || w_mwb_rs2));
    assign w_rs1_fwd    = r_rs1_data;
    assign w_rs2_fwd    = r_rs2_data;
`endif

    assign out_valid = r_valid && !w_hazard;
    assign w_consume = out_valid && out_ready;
    assign in_ready  = !flush && (!r_valid || w_consume);
    assign w_accept  = in_valid && in_ready;

    assign out_a           = r_a_sel ? r_pc : w_rs1_fwd;
    assign out_b           = r_b_sel ? r_imm : w_rs2_fwd;
    assign out_store_data  = w_rs2_fwd;
    assign out_alu_control = r_alu_control;
    assign out_sgn         = r_sgn;
    assign out_pc          = r_pc;
    assign out_rd          = r_rd;
    assign out_reg_write   = r_reg_write;
    assign out_is_load     = r_is_load;

    // NOTE: sequential state uses non-blocking assignments only; reset clears the payload too,
    // so outputs read 0 after reset rather than stale operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_use_rs1     <= 1'b0;
            r_use_rs2     <= 1'b0;
            r_a_sel       <= 1'b0;
            r_b_sel       <= 1'b0;
            r_alu_control <= '0;
            r_sgn         <= 1'b0;
            r_is_load     <= 1'b0;
            r_reg_write   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_pc          <= in_pc;
            r_rs1         <= in_rs1;
            r_rs2         <= in_rs2;
            r_rd          <= in_rd;
            r_rs1_data    <= w_cap_rs1;
            r_rs2_data    <= w_cap_rs2;
            r_imm         <= in_imm;
            r_use_rs1     <= in_use_rs1;
            r_use_rs2     <= in_use_rs2;
            r_a_sel       <= in_a_sel;
            r_b_sel       <= in_b_sel;
            r_alu_control <= in_alu_control;
            r_sgn         <= in_sgn;
            r_is_load     <= in_is_load;
            r_reg_write   <= in_reg_write;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Held entry: keep stored operands current with writebacks it would otherwise miss.
            if (w_mwb_rs1) r_rs1_data <= mwb_result;
            if (w_mwb_rs2) r_rs2_data <= mwb_result;
        end
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow ALU_FWD_EN when it is defined.
module tb_ex_operand_stage;
`ifdef ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2, in_a_sel, in_b_sel, in_sgn, in_is_load, in_reg_write;
    logic [3:0]  in_alu_control;
    logic        exm_valid, exm_reg_write, exm_is_load;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_valid, mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic        out_valid, out_ready, out_sgn, out_reg_write, out_is_load;
    logic [31:0] out_a, out_b, out_store_data, out_pc;
    logic [3:0]  out_alu_control;
    logic [4:0]  out_rd;

    int n_run  = 0;
    int n_fail = 0;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_control(in_alu_control),
        .in_sgn(in_sgn), .in_is_load(in_is_load), .in_reg_write(in_reg_write),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_valid(mwb_valid), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
        .mwb_result(mwb_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_alu_control(out_alu_control), .out_sgn(out_sgn),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_is_load(out_is_load)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_side();
        exm_valid = 0; exm_reg_write = 0; exm_is_load = 0; exm_rd = 0; exm_result = 0;
        mwb_valid = 0; mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    task automatic exm_set(input logic p_ld, input logic [4:0] p_rd, input logic [31:0] p_res);
        exm_valid = 1; exm_reg_write = 1; exm_is_load = p_ld; exm_rd = p_rd; exm_result = p_res;
    endtask

    task automatic mwb_set(input logic [4:0] p_rd, input logic [31:0] p_res);
        mwb_valid = 1; mwb_reg_write = 1; mwb_rd = p_rd; mwb_result = p_res;
    endtask

    task automatic set_beat(input logic [31:0] p_pc, input logic [4:0] p_rs1, input logic [4:0] p_rs2,
                            input logic [4:0] p_rd, input logic [31:0] p_d1, input logic [31:0] p_d2,
                            input logic [31:0] p_imm, input logic p_u1, input logic p_u2,
                            input logic p_asel, input logic p_bsel, input logic [3:0] p_ctrl,
                            input logic p_sgn, input logic p_ld, input logic p_rw);
        in_valid = 1; in_pc = p_pc; in_rs1 = p_rs1; in_rs2 = p_rs2; in_rd = p_rd;
        in_rs1_data = p_d1; in_rs2_data = p_d2; in_imm = p_imm;
        in_use_rs1 = p_u1; in_use_rs2 = p_u2; in_a_sel = p_asel; in_b_sel = p_bsel;
        in_alu_control = p_ctrl; in_sgn = p_sgn; in_is_load = p_ld; in_reg_write = p_rw;
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; out_ready = 1; idle_side();
        set_beat(32'h10, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 1, 1, 0, 0, 4'd2, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", i, out_valid); end
            n_run++; if (out_a !== 32'h0) begin n_fail++; $display("FAIL reset_a[%0d]: got %h want 0", i, out_a); end
            n_run++; if (out_b !== 32'h0) begin n_fail++; $display("FAIL reset_b[%0d]: got %h want 0", i, out_b); end
        end
        rst_n = 1; in_valid = 0; #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_no_dep();
        out_ready = 1;
        set_beat(32'h40, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 1, 1, 0, 0, 4'b0010, 0, 0, 1);
        #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nodep_in_ready: got %b want 1", in_ready); end
        step(); in_valid = 0; #1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nodep_valid: got %b want 1", out_valid); end
        n_run++; if (out_a !== 32'h5) begin n_fail++; $display("FAIL nodep_a: got %h want 5", out_a); end
        n_run++; if (out_b !== 32'h7) begin n_fail++; $display("FAIL nodep_b: got %h want 7", out_b); end
        n_run++; if (out_alu_control !== 4'd2) begin n_fail++; $display("FAIL nodep_ctrl: got %h want 2", out_alu_control); end
        n_run++; if (out_rd !== 5'd3) begin n_fail++; $display("FAIL nodep_rd: got %0d want 3", out_rd); end
        n_run++; if (out_pc !== 32'h40) begin n_fail++; $display("FAIL nodep_pc: got %h want 40", out_pc); end
        n_run++; if (out_store_data !== 32'h7) begin n_fail++; $display("FAIL nodep_store: got %h want 7", out_store_data); end
        n_run++; if (out_reg_write !== 1'b1) begin n_fail++; $display("FAIL nodep_rw: got %b want 1", out_reg_write); end
        step(); #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nodep_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_forward();
        out_ready = 0;
        set_beat(32'h80, 5'd3, 5'd0, 5'd10, 32'h11, 32'h0, 32'h40, 1, 0, 0, 1, 4'd0, 0, 0, 1);
        step(); in_valid = 0;
        exm_set(0, 5'd3, 32'h1234); mwb_set(5'd3, 32'hAAAA); #1;
        n_run++; if (out_a !== (FWD ? 32'h1234 : 32'h11)) begin n_fail++; $display("FAIL fwd_both_a: got %h want %h", out_a, FWD ? 32'h1234 : 32'h11); end
        n_run++; if (out_valid !== FWD) begin n_fail++; $display("FAIL fwd_both_valid: got %b want %b", out_valid, FWD); end
        n_run++; if (out_b !== 32'h40) begin n_fail++; $display("FAIL fwd_imm_b: got %h want 40", out_b); end
        exm_valid = 0; #1;
        n_run++; if (out_a !== (FWD ? 32'hAAAA : 32'h11)) begin n_fail++; $display("FAIL fwd_mwb_a: got %h want %h", out_a, FWD ? 32'hAAAA : 32'h11); end
        n_run++; if (out_valid !== FWD) begin n_fail++; $display("FAIL fwd_mwb_valid: got %b want %b", out_valid, FWD); end
        exm_valid = 1; exm_rd = 5'd0; mwb_valid = 0; #1;
        n_run++; if (out_a !== 32'h11) begin n_fail++; $display("FAIL fwd_rd0_a: got %h want 11", out_a); end
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_rd0_valid: got %b want 1", out_valid); end
        n_run++; if (out_store_data !== 32'h0) begin n_fail++; $display("FAIL fwd_rd0_store: got %h want 0", out_store_data); end
        idle_side(); out_ready = 1; step(); #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        out_ready = 0;
        set_beat(32'hC0, 5'd0, 5'd4, 5'd11, 32'h9, 32'h22, 32'h77, 1, 1, 0, 0, 4'd3, 0, 0, 1);
        step(); in_valid = 0;
        exm_set(1, 5'd4, 32'hBAD); #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_stall_valid: got %b want 0", out_valid); end
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall_in_ready: got %b want 0", in_ready); end
        step(); exm_valid = 0; mwb_set(5'd4, 32'hDEAD); #1;
        n_run++; if (out_valid !== FWD) begin n_fail++; $display("FAIL lu_wb_valid: got %b want %b", out_valid, FWD); end
        n_run++; if (out_b !== (FWD ? 32'hDEAD : 32'h22)) begin n_fail++; $display("FAIL lu_wb_b: got %h want %h", out_b, FWD ? 32'hDEAD : 32'h22); end
        step(); idle_side(); #1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_snoop_valid: got %b want 1", out_valid); end
        n_run++; if (out_b !== 32'hDEAD) begin n_fail++; $display("FAIL lu_snoop_b: got %h want dead", out_b); end
        n_run++; if (out_store_data !== 32'hDEAD) begin n_fail++; $display("FAIL lu_snoop_store: got %h want dead", out_store_data); end
        n_run++; if (out_a !== 32'h9) begin n_fail++; $display("FAIL lu_snoop_a: got %h want 9", out_a); end
        // Replace the held entry with an immediate-only beat in the same cycle it is consumed.
        out_ready = 1;
        set_beat(32'hC4, 5'd0, 5'd4, 5'd12, 32'h9, 32'h22, 32'h77, 0, 0, 0, 1, 4'd3, 0, 0, 1);
        #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_swap_in_ready: got %b want 1", in_ready); end
        step(); in_valid = 0; exm_set(1, 5'd4, 32'hBAD); #1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_nouse_valid: got %b want 1", out_valid); end
        n_run++; if (out_b !== 32'h77) begin n_fail++; $display("FAIL lu_nouse_b: got %h want 77", out_b); end
        n_run++; if (out_rd !== 5'd12) begin n_fail++; $display("FAIL lu_nouse_rd: got %0d want 12", out_rd); end
        n_run++; if (out_store_data !== 32'h22) begin n_fail++; $display("FAIL lu_nouse_store: got %h want 22", out_store_data); end
        idle_side(); step();
    endtask

    task automatic test_index_zero();
        out_ready = 0;
        set_beat(32'hE0, 5'd0, 5'd0, 5'd1, 32'h9, 32'h3, 32'h0, 1, 1, 0, 0, 4'd0, 0, 0, 1);
        step(); in_valid = 0;
        exm_set(1, 5'd0, 32'hBAD); mwb_set(5'd0, 32'h66); #1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL x0_load_valid: got %b want 1", out_valid); end
        n_run++; if (out_b !== 32'h3) begin n_fail++; $display("FAIL x0_mwb_b: got %h want 3", out_b); end
        step(); exm_set(0, 5'd0, 32'h1234); mwb_valid = 0; #1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL x0_alu_valid: got %b want 1", out_valid); end
        n_run++; if (out_a !== 32'h9) begin n_fail++; $display("FAIL x0_a: got %h want 9", out_a); end
        n_run++; if (out_b !== 32'h3) begin n_fail++; $display("FAIL x0_snoop_b: got %h want 3", out_b); end
        idle_side(); out_ready = 1; step();
    endtask

    task automatic test_capture_through();
        out_ready = 0;
        set_beat(32'hF0, 5'd8, 5'd8, 5'd13, 32'h1, 32'h2, 32'h0, 1, 1, 0, 0, 4'd1, 0, 0, 1);
        mwb_set(5'd8, 32'h99);
        step(); in_valid = 0; idle_side(); #1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid: got %b want 1", out_valid); end
        n_run++; if (out_a !== 32'h99) begin n_fail++; $display("FAIL cap_a: got %h want 99", out_a); end
        n_run++; if (out_store_data !== 32'h99) begin n_fail++; $display("FAIL cap_store: got %h want 99", out_store_data); end
        out_ready = 1; step();
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        set_beat(32'h100, 5'd6, 5'd7, 5'd9, 32'h10, 32'h20, 32'h0, 1, 1, 0, 0, 4'd5, 1, 0, 1);
        step(); in_valid = 0; mwb_set(5'd6, 32'h55); #1;
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready0: got %b want 0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            step(); idle_side(); #1;
            n_run++; if (out_a !== 32'h55) begin n_fail++; $display("FAIL bp_a[%0d]: got %h want 55", i, out_a); end
            n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_run++; if (out_b !== 32'h20) begin n_fail++; $display("FAIL bp_b[%0d]: got %h want 20", i, out_b); end
            n_run++; if (out_alu_control !== 4'd5) begin n_fail++; $display("FAIL bp_ctrl[%0d]: got %h want 5", i, out_alu_control); end
            n_run++; if (out_pc !== 32'h100 || out_rd !== 5'd9 || out_sgn !== 1'b1) begin n_fail++; $display("FAIL bp_side[%0d]: got pc=%h rd=%0d sgn=%b want pc=100 rd=9 sgn=1", i, out_pc, out_rd, out_sgn); end
        end
        out_ready = 1; #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", in_ready); end
        step(); #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a;
        out_ready = 1; idle_side();
        for (int i = 0; i < 4; i++) begin
            set_beat(32'h200 + 32'(4 * i), 5'd1, 5'd2, 5'd5, 32'h1000 + 32'(i), 32'h0, 32'h0,
                     1, 1, (i == 3), 0, 4'd0, 0, 0, 1);
            #1;
            n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
            step();
            exp_a = (i == 3) ? 32'h20C : 32'h1000 + 32'(i);
            n_run++; if (out_valid !== 1'b1 || out_a !== exp_a) begin n_fail++; $display("FAIL b2b_out[%0d]: got v=%b a=%h want v=1 a=%h", i, out_valid, out_a, exp_a); end
        end
        in_valid = 0; step(); #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        set_beat(32'h300, 5'd1, 5'd2, 5'd3, 32'h31, 32'h0, 32'h0, 1, 1, 0, 0, 4'd0, 0, 0, 1);
        step();
        set_beat(32'h304, 5'd1, 5'd2, 5'd3, 32'h32, 32'h0, 32'h0, 1, 1, 0, 0, 4'd0, 0, 0, 1);
        flush = 1; #1;
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step(); flush = 0; in_valid = 0; #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready_after: got %b want 1", in_ready); end
        step(); #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_nocapture: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_hold();
        out_ready = 0;
        set_beat(32'h400, 5'd1, 5'd2, 5'd7, 32'h44, 32'h0, 32'h0, 1, 1, 0, 0, 4'd6, 1, 0, 1);
        step(); in_valid = 0; #1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b want 1", out_valid); end
        rst_n = 0; step(); rst_n = 1; #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_run++; if (out_a !== 32'h0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got a=%h pc=%h want 0", out_a, out_pc); end
        n_run++; if (out_rd !== 5'd0 || out_alu_control !== 4'd0 || out_reg_write !== 1'b0 || out_sgn !== 1'b0) begin n_fail++; $display("FAIL midrst_side: got rd=%0d ctrl=%h rw=%b sgn=%b want 0", out_rd, out_alu_control, out_reg_write, out_sgn); end
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_no_dep();
        test_forward();
        test_load_use();
        test_index_zero();
        test_capture_through();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
